// File: rtl/bitext_serial_if.sv
// Handshake bundle for bitext_serial: operand request channel plus result channel.
// Optional cout signal exists only when BITEXT_SERIAL_CARRY_OUT_EN is defined.
interface bitext_serial_if #(
    parameter int unsigned A_WIDTH = 1,
    parameter int unsigned B_WIDTH = 1
) ();
    logic               in_valid;
    logic               in_ready;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic               y;
    logic               busy;
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
    logic               cout;
`endif

    // Producer/consumer side of the block.
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, busy, cout
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, busy, cout
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, busy
    );
`endif
endinterface

// File: rtl/bitext_serial.sv
// Serial sign/carry extraction: extends a and b to SUM_WIDTH, adds them CHUNK bits per
// cycle through a registered carry and returns bit SUM_WIDTH-1 of the wrapped sum.
// Optional macro BITEXT_SERIAL_CARRY_OUT_EN adds cout (bit SUM_WIDTH of the full sum).
module bitext_serial #(
    parameter int unsigned A_WIDTH  = 1,
    parameter int unsigned B_WIDTH  = 1,
    parameter bit          A_SIGNED = 1'b0,
    parameter bit          B_SIGNED = 1'b0,
    parameter int unsigned CHUNK    = 8
) (
    input logic             clk,
    input logic             rst,
    bitext_serial_if.slave  bus
);

    localparam int unsigned SUM_WIDTH = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
    // Clamp so that an oversized CHUNK (e.g. the defaults) still elaborates as one chunk.
    localparam int unsigned CW        = (CHUNK < SUM_WIDTH) ? CHUNK : SUM_WIDTH;
    localparam int unsigned NCHUNK    = (SUM_WIDTH + CW - 1) / CW;
    localparam int unsigned CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Position of sum bit SUM_WIDTH-1 inside the final (possibly partial) chunk.
    localparam int unsigned LAST_BIT  = SUM_WIDTH - 1 - (NCHUNK - 1) * CW;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [SUM_WIDTH-1:0] opa_q, opa_d;
    logic [SUM_WIDTH-1:0] opb_q, opb_d;
    logic                 carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 y_q, y_d;
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
    logic                 cout_q, cout_d;
`endif

    logic [SUM_WIDTH-1:0] ext_a, ext_b;
    logic [CW:0]          chunk_sum;
    logic                 last_chunk;
    logic                 unused_chunk_bits;

    // Sign- or zero-extend both operands to the common sum width.
    always_comb begin
        ext_a = {SUM_WIDTH{A_SIGNED && bus.a[A_WIDTH-1]}};
        ext_a[A_WIDTH-1:0] = bus.a;
        ext_b = {SUM_WIDTH{B_SIGNED && bus.b[B_WIDTH-1]}};
        ext_b[B_WIDTH-1:0] = bus.b;
    end

    // One chunk of the ripple sum; bits beyond SUM_WIDTH are zero after shifting.
    always_comb begin
        chunk_sum  = {1'b0, opa_q[CW-1:0]} + {1'b0, opb_q[CW-1:0]} + (CW + 1)'(carry_q);
        last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
    end

    // Only the carry and the selected result bits are consumed.
    assign unused_chunk_bits = ^chunk_sum;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        cout_d  = cout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    opa_d   = ext_a;
                    opb_d   = ext_b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                carry_d = chunk_sum[CW];
                opa_d   = opa_q >> CW;
                opb_d   = opb_q >> CW;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_chunk) begin
                    y_d     = chunk_sum[LAST_BIT];
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
                    cout_d  = chunk_sum[LAST_BIT+1];
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
            cout_q  <= cout_d;
`endif
        end
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.y         = y_q;
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        bus.cout      = cout_q;
`endif
    end

endmodule

// File: tb/tb_bitext_serial.sv
// Directed bench for bitext_serial: four configurations share clk/rst.
// cout checks are compiled in only with BITEXT_SERIAL_CARRY_OUT_EN.
module tb_bitext_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bitext_serial_if #(.A_WIDTH(8),  .B_WIDTH(8))  if0 ();
    bitext_serial_if #(.A_WIDTH(12), .B_WIDTH(4))  if1 ();
    bitext_serial_if #(.A_WIDTH(12), .B_WIDTH(4))  if2 ();
    bitext_serial_if #(.A_WIDTH(10), .B_WIDTH(10)) if3 ();

    bitext_serial #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1'b0), .B_SIGNED(1'b0), .CHUNK(4))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    bitext_serial #(.A_WIDTH(12), .B_WIDTH(4), .A_SIGNED(1'b0), .B_SIGNED(1'b1), .CHUNK(4))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    bitext_serial #(.A_WIDTH(12), .B_WIDTH(4), .A_SIGNED(1'b0), .B_SIGNED(1'b0), .CHUNK(4))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    bitext_serial #(.A_WIDTH(10), .B_WIDTH(10), .A_SIGNED(1'b0), .B_SIGNED(1'b0), .CHUNK(4))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.a = '0; if3.b = '0; if3.out_ready = 1'b0;

        // Reset state.
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(if0.in_ready), 1);
        check("rst_out_valid", 32'(if0.out_valid), 0);
        check("rst_y", 32'(if0.y), 0);
        check("rst_busy", 32'(if0.busy), 0);
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        check("rst_cout", 32'(if0.cout), 0);
`endif

        // 8+8 unsigned: 0x70 + 0x10 = 0x80, y=1 two cycles after accept.
        if0.a = 8'h70; if0.b = 8'h10; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0; if0.a = 8'h00; if0.b = 8'h00;
        check("t1_busy", 32'(if0.busy), 1);
        check("t1_in_ready_run", 32'(if0.in_ready), 0);
        tick();
        check("t1_ov_early", 32'(if0.out_valid), 0);
        tick();
        check("t1_ov", 32'(if0.out_valid), 1);
        check("t1_y", 32'(if0.y), 1);
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        check("t1_cout", 32'(if0.cout), 0);
`endif
        // Backpressure with operand/in_valid churn.
        for (int i = 0; i < 5; i++) begin
            if0.a = 8'(i * 37 + 5); if0.b = 8'(255 - i * 11); if0.in_valid = i[0];
            tick();
            check("bp_ov", 32'(if0.out_valid), 1);
            check("bp_y", 32'(if0.y), 1);
            check("bp_in_ready", 32'(if0.in_ready), 0);
        end
        if0.in_valid = 1'b0; if0.out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(if0.in_ready), 1);
        check("bp_release_ov", 32'(if0.out_valid), 0);

        // 0xFF + 0x01 wraps to 0x00 with out_ready held high (minimum initiation interval).
        if0.a = 8'hFF; if0.b = 8'h01; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        tick();
        check("t2_ov_early", 32'(if0.out_valid), 0);
        tick();
        check("t2_ov", 32'(if0.out_valid), 1);
        check("t2_y", 32'(if0.y), 0);
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        check("t2_cout", 32'(if0.cout), 1);
`endif
        tick();
        check("t2_idle", 32'(if0.in_ready), 1);
        if0.out_ready = 1'b0;

        // 12-bit a with 4-bit b, signed vs unsigned extension of b.
        if1.a = 12'h800; if1.b = 4'hF; if1.in_valid = 1'b1;
        if2.a = 12'h800; if2.b = 4'hF; if2.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0; if2.in_valid = 1'b0;
        tick(); tick();
        check("sx_ov_early", 32'(if1.out_valid), 0);
        check("zx_ov_early", 32'(if2.out_valid), 0);
        tick();
        check("sx_ov", 32'(if1.out_valid), 1);
        check("sx_y", 32'(if1.y), 0);
        check("zx_ov", 32'(if2.out_valid), 1);
        check("zx_y", 32'(if2.y), 1);
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        check("sx_cout", 32'(if1.cout), 1);
        check("zx_cout", 32'(if2.cout), 0);
`endif
        if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        tick();
        check("sx_idle", 32'(if1.in_ready), 1);
        check("zx_idle", 32'(if2.in_ready), 1);
        if1.out_ready = 1'b0; if2.out_ready = 1'b0;

        // 10-bit, partial last chunk: 0x1FF + 0x001 = 0x200, y=1 three cycles after accept.
        if3.a = 10'h1FF; if3.b = 10'h001; if3.in_valid = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        tick(); tick();
        check("p_ov_early", 32'(if3.out_valid), 0);
        tick();
        check("p_ov", 32'(if3.out_valid), 1);
        check("p_y", 32'(if3.y), 1);

        // Reset while holding a result in DONE clears y.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_ov", 32'(if3.out_valid), 0);
        check("rd_y", 32'(if3.y), 0);
        check("rd_in_ready", 32'(if3.in_ready), 1);

        // Reset during the second RUN cycle drops the transaction.
        if3.a = 10'h1FF; if3.b = 10'h001; if3.in_valid = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        tick();
        check("rr_busy", 32'(if3.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_in_ready", 32'(if3.in_ready), 1);
        check("rr_ov", 32'(if3.out_valid), 0);
        check("rr_y", 32'(if3.y), 0);
        check("rr_busy_clr", 32'(if3.busy), 0);
        tick(); tick();
        check("rr_no_output", 32'(if3.out_valid), 0);

        // Fresh transactions after the abort: 0x100 + 0x0FF = 0x1FF, then 0x3FF + 0x3FF.
        if3.a = 10'h100; if3.b = 10'h0FF; if3.in_valid = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        tick(); tick(); tick();
        check("f1_ov", 32'(if3.out_valid), 1);
        check("f1_y", 32'(if3.y), 0);
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        check("f1_cout", 32'(if3.cout), 0);
`endif
        if3.out_ready = 1'b1;
        tick();
        if3.out_ready = 1'b0;
        if3.a = 10'h3FF; if3.b = 10'h3FF; if3.in_valid = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        tick(); tick(); tick();
        check("f2_ov", 32'(if3.out_valid), 1);
        check("f2_y", 32'(if3.y), 1);
`ifdef BITEXT_SERIAL_CARRY_OUT_EN
        check("f2_cout", 32'(if3.cout), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitext_serial.md
# bitext_serial

Multi-cycle, handshaked evaluator of the sign/carry-extraction primitive: accepts operands A and B, extends both to SUM_WIDTH = max(A_WIDTH, B_WIDTH), and propagates the sum CHUNK bits per cycle through a registered carry. It emits Y = bit SUM_WIDTH-1 of the wrapped sum. It is the stage that feeds comparison and sign results into downstream circuit-generation logic when a full-width single-cycle adder is too costly in depth. The operand-staging and extension front end is integrated.

## Interface
- A_WIDTH, 1: width of operand A.
- B_WIDTH, 1: width of operand B.
- A_SIGNED, 0: 1 means A is sign-extended to SUM_WIDTH; 0 means zero-extended.
- B_SIGNED, 0: same rule for B.
- CHUNK, 8: bits processed per RUN cycle; legal range 1..SUM_WIDTH.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- a  in  A_WIDTH  operand A.
- b  in  B_WIDTH  operand B.
- out_valid  out  1  result y is valid.
- out_ready  in  1  consumer accepts the result.
- y  out  1  bit SUM_WIDTH-1 of (ext(a) + ext(b)) mod 2^SUM_WIDTH.
- busy  out  1  high in RUN or DONE.

## Operation
- NCHUNK = ceil(SUM_WIDTH / CHUNK). The last chunk is partial when SUM_WIDTH is not a multiple of CHUNK; its unused upper bits are ignored.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture ext(a) and ext(b) into SUM_WIDTH shift registers, clear carry, set cnt=0, go to RUN.
- RUN, one chunk per cycle:
  - Compute the chunk sum = low CHUNK bits of each register + carry.
  - Update carry to the chunk carry-out.
  - Shift both registers right by CHUNK and increment cnt.
  - On cnt = NCHUNK-1: latch y = chunk-sum bit (SUM_WIDTH-1 - (NCHUNK-1)*CHUNK), then go to DONE.
- DONE:
  - out_valid=1; y is held stable.
  - On out_ready, go to IDLE.
- in_ready is asserted only in IDLE. There is no overlap between transactions.
- Inputs a and b are sampled only on the accept edge. Later changes to them do not affect the result.
- Arithmetic is modulo 2^SUM_WIDTH. Overflow is not flagged unless the macro under Configuration is enabled.
- Reset in any state:
  - Return to IDLE and clear carry, cnt and y.
  - An in-flight transaction is dropped and produces no output.
  - Reset has priority over in_valid and out_ready on the same edge.

## Timing
- Reset values, after the reset edge: state=IDLE, in_ready=1, out_valid=0, y=0, busy=0, carry=0.
- Accept edge T. RUN occupies edges T+1..T+NCHUNK. out_valid rises after edge T+NCHUNK.
- Minimum latency from accept to out_valid is NCHUNK cycles.
- Minimum initiation interval is NCHUNK+2 cycles, with out_ready held high.
- out_valid and y remain stable until the out_ready handshake, regardless of the in_valid or a/b activity.
- out_ready asserted outside DONE is ignored.
- in_valid asserted outside IDLE is ignored; the source must hold it until in_ready.
- NCHUNK=1 degenerates to a single RUN cycle.

## Configuration
- BITEXT_SERIAL_CARRY_OUT_EN, when defined:
  - Adds output port cout (1 bit), which is bit SUM_WIDTH of ext(a) + ext(b) computed at SUM_WIDTH+1 bits.
  - cout is latched alongside y and follows the same valid, hold and reset rules (reset value 0).
- When undefined: no cout port and no extra logic. The behaviour of y is identical in both builds.

## Test plan
- A_WIDTH=B_WIDTH=8, CHUNK=4, unsigned; a=0x70, b=0x10 -> sum 0x80. Expect y=1 two cycles after accept; cout=0 when enabled.
- Same configuration; a=0xFF, b=0x01 -> sum wraps to 0x00. Expect y=0; cout=1 when enabled.
- A_WIDTH=12, B_WIDTH=4, CHUNK=4, a=0x800, b=0xF:
  - With B_SIGNED=1, expect y=0 (sum 0x7FF).
  - With B_SIGNED=0, expect y=1 (sum 0x80F).
- A_WIDTH=B_WIDTH=10, CHUNK=4 (NCHUNK=3, partial last chunk); a=0x1FF, b=0x001 -> sum 0x200. Expect y=1 exactly three cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Expect out_valid and y held and in_ready=0. Toggling a/b and in_valid has no effect. out_ready=1 returns to IDLE on the next edge.
- Assert rst during the second RUN cycle. The next cycle must show in_ready=1, out_valid=0, y=0 and busy=0. A fresh transaction then yields its correct y with no residue from the aborted one.
